// File: rtl/led_blink_seq_pkg.sv
// Shared definitions for the LED blink sequencer: state encodings,
// default prescaler ratio and a small state-decode helper.
package led_blink_seq_pkg;

    typedef logic [1:0] blink_state_t;

    localparam blink_state_t ST_IDLE = 2'd0;
    localparam blink_state_t ST_ON   = 2'd1;
    localparam blink_state_t ST_OFF  = 2'd2;
    localparam blink_state_t ST_DONE = 2'd3;

    localparam int unsigned PRESC_DEFAULT = 50000;

    // ON and OFF are the only states in which the prescaler runs.
    function automatic logic is_active(input blink_state_t st);
        return (st == ST_ON) || (st == ST_OFF);
    endfunction

endpackage

// File: rtl/blink_tick_gen.sv
// Prescaler: counts 0..PRESC-1 while enabled and emits a one-cycle tick
// in the last count. clr has priority and parks the count at 0.
module blink_tick_gen
    import led_blink_seq_pkg::*;
#(
    parameter int unsigned PRESC = PRESC_DEFAULT
) (
    input  logic sysclk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned W = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [W-1:0] TC = W'(PRESC - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, wrap at terminal count, or advance.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == TC) ? '0 : cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && !clr && (cnt_q == TC);

endmodule

// File: rtl/led_blink_seq.sv
// LED blink sequencer: accepts a (count, half-period) request and drives
// led_o through count on/off cycles, each phase lasting half ticks.
//
// state | meaning
// IDLE  | ready for a request, LED off
// ON    | LED on, counting down the on-phase ticks
// OFF   | LED off, counting down the off-phase ticks
// DONE  | one-cycle completion pulse, then back to IDLE
module led_blink_seq
    import led_blink_seq_pkg::*;
#(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned PER_W = 16,
    parameter int unsigned PRESC = PRESC_DEFAULT
) (
    input  logic             sysclk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] req_count,
    input  logic [PER_W-1:0] req_half,
    input  logic             abort,
    output logic             led_o,
    output logic             busy,
    output logic             done
);

    blink_state_t     state_q, state_d;
    logic             led_q, led_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [PER_W-1:0] phase_q, phase_d;
    logic [PER_W-1:0] half_q, half_d;
    logic [PER_W-1:0] half_in;
    logic             tick;
    logic             active;

    assign active  = is_active(state_q);
    // A zero half-period would never terminate a phase; treat it as one tick.
    assign half_in = (req_half == '0) ? PER_W'(1) : req_half;

    blink_tick_gen #(
        .PRESC (PRESC)
    ) u_tick (
        .sysclk  (sysclk),
        .reset_n (reset_n),
        .clr     (abort || !active),
        .en      (active),
        .tick    (tick)
    );

    // Next-state logic. Phase counter is a down-counter reloaded from the
    // latched half-period; it hands over to the next phase when it is 1 at a tick.
    always_comb begin
        state_d  = state_q;
        led_d    = led_q;
        remain_d = remain_q;
        phase_d  = phase_q;
        half_d   = half_q;
        if (abort) begin
            state_d  = ST_IDLE;
            led_d    = 1'b0;
            remain_d = '0;
            phase_d  = '0;
            half_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        half_d   = half_in;
                        remain_d = req_count;
                        if (req_count == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_ON;
                            led_d   = 1'b1;
                            phase_d = half_in;
                        end
                    end
                end
                ST_ON: begin
                    if (tick) begin
                        if (phase_q == PER_W'(1)) begin
                            state_d = ST_OFF;
                            led_d   = 1'b0;
                            phase_d = half_q;
                        end else begin
                            phase_d = phase_q - PER_W'(1);
                        end
                    end
                end
                ST_OFF: begin
                    if (tick) begin
                        if (phase_q == PER_W'(1)) begin
                            remain_d = remain_q - CNT_W'(1);
                            if (remain_q == CNT_W'(1)) begin
                                state_d = ST_DONE;
                                phase_d = '0;
                            end else begin
                                state_d = ST_ON;
                                led_d   = 1'b1;
                                phase_d = half_q;
                            end
                        end else begin
                            phase_d = phase_q - PER_W'(1);
                        end
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    remain_d = '0;
                    phase_d  = '0;
                end
            endcase
        end
    end

    // State, LED and counter registers.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            led_q    <= 1'b0;
            remain_q <= '0;
            phase_q  <= '0;
            half_q   <= '0;
        end else begin
            state_q  <= state_d;
            led_q    <= led_d;
            remain_q <= remain_d;
            phase_q  <= phase_d;
            half_q   <= half_d;
        end
    end

    assign led_o     = led_q;
    assign busy      = active;
    assign done      = (state_q == ST_DONE);
    assign req_ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_led_blink_seq.sv
// Bench for led_blink_seq with PRESC=4. Expected per-cycle output vectors
// {led_o, busy, done, req_ready} are pushed when a request is driven and
// popped once per cycle as the DUT produces them.
module tb_led_blink_seq;

    localparam int P = 4;

    logic        sysclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [7:0]  req_count = '0;
    logic [15:0] req_half = '0;
    logic        abort = 1'b0;
    logic        req_ready, led_o, busy, done;

    int vectors = 0;
    int miscompares = 0;
    logic [3:0] sb[$];

    always #5 sysclk = ~sysclk;

    led_blink_seq #(.CNT_W(8), .PER_W(16), .PRESC(P)) dut (
        .sysclk    (sysclk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_count (req_count),
        .req_half  (req_half),
        .abort     (abort),
        .led_o     (led_o),
        .busy      (busy),
        .done      (done)
    );

    // Expected vectors for cycles first..last after an accept at cycle 0.
    task automatic push_seq(input int cnt, input int half, input int first, input int last);
        int h, t;
        logic [3:0] e;
        h = (half == 0) ? 1 : half;
        t = 2 * cnt * h * P;
        for (int c = first; c <= last; c++) begin
            if (cnt == 0)       e = {1'b0, 1'b0, c == 1, c >= 2};
            else if (c <= t)    e = {((c - 1) / (h * P)) % 2 == 0, 1'b1, 1'b0, 1'b0};
            else if (c == t + 1) e = 4'b0010;
            else                e = 4'b0001;
            sb.push_back(e);
        end
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) sb.push_back(4'b0001);
    endtask

    task automatic test_reset();
        logic [3:0] e;
        push_idle(2);
        #3;
        e = sb.pop_front();
        vectors++;
        if ({led_o, busy, done, req_ready} !== e) begin
            miscompares++;
            $display("FAIL reset_hold: got %b want %b", {led_o, busy, done, req_ready}, e);
        end
        @(negedge sysclk) reset_n = 1'b1;
        @(posedge sysclk); #1;
        e = sb.pop_front();
        vectors++;
        if ({led_o, busy, done, req_ready} !== e) begin
            miscompares++;
            $display("FAIL reset_release: got %b want %b", {led_o, busy, done, req_ready}, e);
        end
    endtask

    task automatic test_three_blinks();
        logic [3:0] e;
        req_count = 8'd3; req_half = 16'd2; req_valid = 1'b1;
        push_seq(3, 2, 1, 54);
        for (int c = 1; c <= 54; c++) begin
            @(posedge sysclk); #1;
            req_valid = 1'b0;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++; $display("FAIL three_blinks: queue empty at cycle %0d", c);
            end else begin
                e = sb.pop_front();
                if ({led_o, busy, done, req_ready} !== e) begin
                    miscompares++;
                    $display("FAIL three_blinks cycle %0d: got %b want %b", c, {led_o, busy, done, req_ready}, e);
                end
            end
        end
    endtask

    task automatic test_zero_count();
        logic [3:0] e;
        req_count = 8'd0; req_half = 16'd5; req_valid = 1'b1;
        push_seq(0, 5, 1, 6);
        for (int c = 1; c <= 6; c++) begin
            @(posedge sysclk); #1;
            req_valid = 1'b0;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++; $display("FAIL zero_count: queue empty at cycle %0d", c);
            end else begin
                e = sb.pop_front();
                if ({led_o, busy, done, req_ready} !== e) begin
                    miscompares++;
                    $display("FAIL zero_count cycle %0d: got %b want %b", c, {led_o, busy, done, req_ready}, e);
                end
            end
        end
    endtask

    task automatic test_zero_half();
        logic [3:0] e;
        req_count = 8'd1; req_half = 16'd0; req_valid = 1'b1;
        push_seq(1, 0, 1, 12);
        for (int c = 1; c <= 12; c++) begin
            @(posedge sysclk); #1;
            req_valid = 1'b0;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++; $display("FAIL zero_half: queue empty at cycle %0d", c);
            end else begin
                e = sb.pop_front();
                if ({led_o, busy, done, req_ready} !== e) begin
                    miscompares++;
                    $display("FAIL zero_half cycle %0d: got %b want %b", c, {led_o, busy, done, req_ready}, e);
                end
            end
        end
    endtask

    task automatic test_abort();
        logic [3:0] e;
        req_count = 8'd4; req_half = 16'd1; req_valid = 1'b1;
        push_seq(4, 1, 1, 6);
        push_idle(40);
        for (int c = 1; c <= 46; c++) begin
            @(posedge sysclk); #1;
            req_valid = 1'b0;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++; $display("FAIL abort: queue empty at cycle %0d", c);
            end else begin
                e = sb.pop_front();
                if ({led_o, busy, done, req_ready} !== e) begin
                    miscompares++;
                    $display("FAIL abort cycle %0d: got %b want %b", c, {led_o, busy, done, req_ready}, e);
                end
            end
            abort = (c == 6);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e;
        req_count = 8'd1; req_half = 16'd1; req_valid = 1'b1;
        push_seq(1, 1, 1, 10);
        push_seq(2, 1, 1, 20);
        for (int c = 1; c <= 30; c++) begin
            @(posedge sysclk); #1;
            if (c == 1) req_count = 8'd2;
            if (c == 11) req_valid = 1'b0;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++; $display("FAIL back_to_back: queue empty at cycle %0d", c);
            end else begin
                e = sb.pop_front();
                if ({led_o, busy, done, req_ready} !== e) begin
                    miscompares++;
                    $display("FAIL back_to_back cycle %0d: got %b want %b", c, {led_o, busy, done, req_ready}, e);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] e;
        req_count = 8'd2; req_half = 16'd1; req_valid = 1'b1;
        push_seq(2, 1, 1, 5);
        push_idle(1 + 25);
        for (int c = 1; c <= 30; c++) begin
            @(posedge sysclk); #1;
            req_valid = 1'b0;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++; $display("FAIL reset_mid: queue empty at cycle %0d", c);
            end else begin
                e = sb.pop_front();
                if ({led_o, busy, done, req_ready} !== e) begin
                    miscompares++;
                    $display("FAIL reset_mid cycle %0d: got %b want %b", c, {led_o, busy, done, req_ready}, e);
                end
            end
            if (c == 5) begin
                reset_n = 1'b0;
                #1;
                e = sb.pop_front();
                vectors++;
                if ({led_o, busy, done, req_ready} !== e) begin
                    miscompares++;
                    $display("FAIL reset_async: got %b want %b", {led_o, busy, done, req_ready}, e);
                end
            end
            if (c == 8) reset_n = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_three_blinks();
        test_zero_count();
        test_zero_half();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d leftover want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
